// File: rtl/paddle_input_conditioner_if.sv
// Paddle button pins in, clean movement levels and press pulses out.
// master drives the raw buttons; slave is the conditioner.
interface paddle_input_conditioner_if;
  logic btn_up_raw;
  logic btn_down_raw;
  logic move_up_control;
  logic move_down_control;
  logic up_press_pulse;
  logic down_press_pulse;

  modport master (
    output btn_up_raw,
    output btn_down_raw,
    input  move_up_control,
    input  move_down_control,
    input  up_press_pulse,
    input  down_press_pulse
  );

  modport slave (
    input  btn_up_raw,
    input  btn_down_raw,
    output move_up_control,
    output move_down_control,
    output up_press_pulse,
    output down_press_pulse
  );
endinterface

// File: rtl/paddle_input_conditioner.sv
// Per-player paddle front end: sync, debounce, conflict resolve.
// Index 0 is the up button, index 1 the down button.
module paddle_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                             clk,
  input  logic                             reset,
  paddle_input_conditioner_if.slave        pad
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } db_state_e;

  logic [1:0] raw;
  logic [1:0] db;
  logic [1:0] acc;
  logic [1:0] acc_q;

  assign raw = {pad.btn_down_raw, pad.btn_up_raw};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic          s1;
    logic          s2;
    db_state_e     state;
    db_state_e     state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        state <= RELEASED;
        cnt   <= '0;
      end else begin
        s1    <= raw[i];
        s2    <= s1;
        state <= state_nx;
        cnt   <= cnt_nx;
      end
    end

    // Any opposite sample in a PEND state aborts and clears the count
    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
        RELEASED: begin
          if (s2) begin
            state_nx = PRESS_PEND;
            cnt_nx   = '0;
          end
        end
        PRESS_PEND: begin
          if (!s2) begin
            state_nx = RELEASED;
            cnt_nx   = '0;
          end else if (cnt == LAST) begin
            state_nx = PRESSED;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!s2) begin
            state_nx = RELEASE_PEND;
            cnt_nx   = '0;
          end
        end
        RELEASE_PEND: begin
          if (s2) begin
            state_nx = PRESSED;
            cnt_nx   = '0;
          end else if (cnt == LAST) begin
            state_nx = RELEASED;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = RELEASED;
          cnt_nx   = '0;
        end
      endcase
    end

    assign db[i]  = (state == PRESSED) || (state == RELEASE_PEND);
    assign acc[i] = (state == PRESS_PEND) && (state_nx == PRESSED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q                 <= 2'b00;
      pad.move_up_control   <= 1'b0;
      pad.move_down_control <= 1'b0;
      pad.up_press_pulse    <= 1'b0;
      pad.down_press_pulse  <= 1'b0;
    end else begin
      acc_q                 <= acc;
      pad.move_up_control   <= db[0] & ~db[1];
      pad.move_down_control <= db[1] & ~db[0];
      pad.up_press_pulse    <= acc_q[0];
      pad.down_press_pulse  <= acc_q[1];
    end
  end
endmodule

// File: tb/tb_paddle_input_conditioner.sv
// Bench: two conditioners (debounce 4 and 8) on shared buttons,
// checked against a run-length model plus directed literal checks.
module tb_paddle_input_conditioner;
  logic clk;
  logic reset;
  logic up_raw;
  logic down_raw;
  bit   chk_en;
  int   total;
  int   bad;

  paddle_input_conditioner_if if4();
  paddle_input_conditioner_if if8();

  assign if4.btn_up_raw   = up_raw;
  assign if4.btn_down_raw = down_raw;
  assign if8.btn_up_raw   = up_raw;
  assign if8.btn_down_raw = down_raw;

  paddle_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .pad   (if4.slave)
  );

  paddle_input_conditioner #(.DEBOUNCE_CYCLES(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .pad   (if8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] d_ctrl[2];
  logic [1:0] d_pulse[2];
  assign d_ctrl[0]  = {if4.move_down_control, if4.move_up_control};
  assign d_pulse[0] = {if4.down_press_pulse, if4.up_press_pulse};
  assign d_ctrl[1]  = {if8.move_down_control, if8.move_up_control};
  assign d_pulse[1] = {if8.down_press_pulse, if8.up_press_pulse};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Model: a debounced level flips once the synchronised samples have
  // disagreed with it for D+1 consecutive clocks; outputs lag one clock.
  int dcy[2] = '{4, 8};
  bit [1:0] m_s1, m_s2;
  bit [1:0] m_db[2];
  bit [1:0] m_rose[2];
  bit [1:0] m_ctrl[2];
  bit [1:0] m_pulse[2];
  int       m_run[2][2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s1 = 2'b00;
      m_s2 = 2'b00;
      for (int i = 0; i < 2; i++) begin
        m_db[i] = 2'b00; m_rose[i] = 2'b00;
        m_ctrl[i] = 2'b00; m_pulse[i] = 2'b00;
        m_run[i][0] = 0; m_run[i][1] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_ctrl[i][0] = m_db[i][0] & ~m_db[i][1];
        m_ctrl[i][1] = m_db[i][1] & ~m_db[i][0];
        m_pulse[i]   = m_rose[i];
      end
      for (int i = 0; i < 2; i++) begin
        for (int b = 0; b < 2; b++) begin
          m_rose[i][b] = 1'b0;
          if (m_s2[b] != m_db[i][b]) begin
            m_run[i][b]++;
            if (m_run[i][b] == dcy[i] + 1) begin
              m_db[i][b]   = ~m_db[i][b];
              m_run[i][b]  = 0;
              m_rose[i][b] = m_db[i][b];
            end
          end else begin
            m_run[i][b] = 0;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = {down_raw, up_raw};
    end
  end

  logic [1:0] prev_pulse[2];
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("ctrl%0d", dcy[i]), 32'(d_ctrl[i]), 32'(m_ctrl[i]));
        chk($sformatf("pulse%0d", dcy[i]), 32'(d_pulse[i]), 32'(m_pulse[i]));
        chk($sformatf("both_ctrl%0d", dcy[i]), 32'(d_ctrl[i] == 2'b11), 0);
        chk($sformatf("long_pulse%0d", dcy[i]),
            32'(d_pulse[i] & prev_pulse[i]), 0);
        prev_pulse[i] = d_pulse[i];
      end
    end else begin
      prev_pulse[0] = 2'b00;
      prev_pulse[1] = 2'b00;
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0; chk_en = 1'b0;
    reset = 1'b1; up_raw = 1'b0; down_raw = 1'b0;
    tick(3);
    reset = 1'b0;
    chk_en = 1'b1;
    tick(2);
    chk("reset_ctrl4", 32'(d_ctrl[0]), 0);
    chk("reset_pulse8", 32'(d_pulse[1]), 0);

    // press up and hold
    up_raw = 1'b1;
    tick(7);
    chk("up_e6_ctrl4", 32'(d_ctrl[0]), 32'h0);
    tick(1);
    chk("up_e7_ctrl4", 32'(d_ctrl[0]), 32'h1);
    chk("up_e7_pulse4", 32'(d_pulse[0]), 32'h1);
    tick(1);
    chk("up_e8_pulse4", 32'(d_pulse[0]), 32'h0);
    chk("up_e8_ctrl4", 32'(d_ctrl[0]), 32'h1);
    tick(2);
    chk("up_e10_ctrl8", 32'(d_ctrl[1]), 32'h0);
    tick(1);
    chk("up_e11_ctrl8", 32'(d_ctrl[1]), 32'h1);
    chk("up_e11_pulse8", 32'(d_pulse[1]), 32'h1);

    // down pressed while up held
    tick(3);
    down_raw = 1'b1;
    tick(7);
    chk("conf_e6_ctrl4", 32'(d_ctrl[0]), 32'h1);
    tick(1);
    chk("conf_e7_ctrl4", 32'(d_ctrl[0]), 32'h0);
    chk("conf_e7_pulse4", 32'(d_pulse[0]), 32'h2);
    tick(10);
    chk("conf_ctrl8", 32'(d_ctrl[1]), 32'h0);
    down_raw = 1'b0;
    tick(7);
    chk("rel_e6_ctrl4", 32'(d_ctrl[0]), 32'h0);
    tick(1);
    chk("rel_e7_ctrl4", 32'(d_ctrl[0]), 32'h1);
    tick(5);
    chk("rel_ctrl8", 32'(d_ctrl[1]), 32'h1);

    // short low bounce while held
    up_raw = 1'b0;
    tick(2);
    up_raw = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      chk("bounce_ctrl4", 32'(d_ctrl[0]), 32'h1);
      chk("bounce_pulse4", 32'(d_pulse[0]), 32'h0);
    end

    // release, then a 3-cycle glitch is rejected
    up_raw = 1'b0;
    tick(15);
    chk("released_ctrl8", 32'(d_ctrl[1]), 32'h0);
    up_raw = 1'b1;
    tick(3);
    up_raw = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick(1);
      chk("glitch_ctrl4", 32'(d_ctrl[0]), 32'h0);
      chk("glitch_pulse4", 32'(d_pulse[0]), 32'h0);
    end

    // reset in PRESS_PEND at cnt=2
    up_raw = 1'b1;
    tick(5);
    reset = 1'b1;
    #1 chk("rst_pend_ctrl4", 32'(d_ctrl[0]), 32'h0);
    tick(1);
    reset = 1'b0;
    tick(7);
    chk("rst_pend_e6_ctrl4", 32'(d_ctrl[0]), 32'h0);
    tick(1);
    chk("rst_pend_e7_ctrl4", 32'(d_ctrl[0]), 32'h1);
    chk("rst_pend_e7_pulse4", 32'(d_pulse[0]), 32'h1);
    tick(5);

    // reset while PRESSED clears outputs asynchronously
    reset = 1'b1;
    #1;
    chk("rst_pressed_ctrl4", 32'(d_ctrl[0]), 32'h0);
    chk("rst_pressed_ctrl8", 32'(d_ctrl[1]), 32'h0);
    tick(2);
    reset = 1'b0;
    tick(7);
    chk("rst_held_e6_ctrl4", 32'(d_ctrl[0]), 32'h0);
    tick(1);
    chk("rst_held_e7_ctrl4", 32'(d_ctrl[0]), 32'h1);
    chk("rst_held_e7_pulse4", 32'(d_pulse[0]), 32'h1);

    // random bouncing on both buttons
    up_raw = 1'b0;
    tick(15);
    for (int k = 0; k < 10000; k++) begin
      tick(1);
      if ($urandom_range(0, 7) == 0) up_raw = ~up_raw;
      if ($urandom_range(0, 9) == 0) down_raw = ~down_raw;
      if ($urandom_range(0, 2999) == 0) begin
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
      end
    end
    tick(2);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
